// File: rtl/hazard_stall.sv
// rtl/hazard_stall.sv - load-use and mult/div interlock controller for the 5-stage pipeline
module hazard_stall #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             fd_use_rs,
  input  logic             fd_use_rt,
  input  logic [4:0]       dx_rd,
  input  logic             dx_rwe,
  input  logic             dx_is_load,
  input  logic             dx_is_multdiv,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             stall_front,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             md_start,
  output logic             md_done,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Counter must hold MD_TIMEOUT itself: it increments once more on the exit cycle.
  localparam int TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(MD_TIMEOUT - 1);

  state_t        state, next_state;
  logic [TW-1:0] cnt;
  logic          err;
  logic          lu;
  logic          stall_int, bdx_int, bxm_int, start_int, done_int, error_int;

  always_comb begin
    lu = dx_is_load & dx_rwe & (dx_rd != 5'd0) &
         ((fd_use_rs & (fd_rs == dx_rd)) | (fd_use_rt & (fd_rt == dx_rd)));
  end

  always_comb begin
    next_state = state;
    stall_int  = 1'b0;
    bdx_int    = 1'b0;
    bxm_int    = 1'b0;
    start_int  = 1'b0;
    done_int   = 1'b0;
    error_int  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dx_is_multdiv) begin
          start_int  = 1'b1;
          stall_int  = 1'b1;
          bxm_int    = 1'b1;
          next_state = BUSY;
        end else if (lu) begin
          // PC and F/D hold while D/X advances into a nop.
          stall_int = 1'b1;
          bdx_int   = 1'b1;
        end
      end
      BUSY: begin
        stall_int = 1'b1;
        bxm_int   = 1'b1;
        if (md_ready || cnt == T_LAST) next_state = DONE;
      end
      DONE: begin
        done_int   = 1'b1;
        error_int  = err;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall_front = reset & stall_int;
    bubble_dx   = reset & bdx_int;
    bubble_xm   = reset & bxm_int;
    md_start    = reset & start_int;
    md_done     = reset & done_int;
    md_error    = reset & error_int;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      err         <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) cnt <= '0;
      else if (state == BUSY) cnt <= cnt + TW'(1);
      // A ready on the final timeout cycle still reports the unit's own status.
      if (state == BUSY) begin
        if (md_ready) err <= md_exception;
        else if (cnt == T_LAST) err <= 1'b1;
      end
      if (stall_int && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall.sv
// tb/tb_hazard_stall.sv - directed self-checking bench for hazard_stall
module tb_hazard_stall;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  fd_rs, fd_rt, dx_rd;
  logic        fd_use_rs, fd_use_rt, dx_rwe, dx_is_load, dx_is_multdiv;
  logic        md_ready, md_exception;
  logic        stall_front, bubble_dx, bubble_xm, md_start, md_done, md_error;
  logic [15:0] stall_count;
  logic        s_stall_front, s_bubble_dx, s_bubble_xm, s_md_start, s_md_done, s_md_error;
  logic [3:0]  s_stall_count;

  int n_pass  = 0;
  int n_total = 0;

  hazard_stall #(.MD_TIMEOUT(40), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt),
    .dx_rd(dx_rd), .dx_rwe(dx_rwe), .dx_is_load(dx_is_load), .dx_is_multdiv(dx_is_multdiv),
    .md_ready(md_ready), .md_exception(md_exception),
    .stall_front(stall_front), .bubble_dx(bubble_dx), .bubble_xm(bubble_xm),
    .md_start(md_start), .md_done(md_done), .md_error(md_error), .stall_count(stall_count)
  );

  hazard_stall #(.MD_TIMEOUT(40), .CNT_W(4)) u_sat (
    .clock(clock), .reset(reset),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt),
    .dx_rd(dx_rd), .dx_rwe(dx_rwe), .dx_is_load(dx_is_load), .dx_is_multdiv(dx_is_multdiv),
    .md_ready(md_ready), .md_exception(md_exception),
    .stall_front(s_stall_front), .bubble_dx(s_bubble_dx), .bubble_xm(s_bubble_xm),
    .md_start(s_md_start), .md_done(s_md_done), .md_error(s_md_error), .stall_count(s_stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, stall_front, bubble_dx, bubble_xm, md_start, md_done, md_error}, {26'd0, exp});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    fd_rs = 5'd0; fd_rt = 5'd0; fd_use_rs = 1'b0; fd_use_rt = 1'b0;
    dx_rd = 5'd0; dx_rwe = 1'b0; dx_is_load = 1'b0; dx_is_multdiv = 1'b0;
    md_ready = 1'b0; md_exception = 1'b0;
  endtask

  task automatic set_load_use;
    clear_inputs();
    dx_is_load = 1'b1; dx_rwe = 1'b1; dx_rd = 5'd5; fd_rs = 5'd5; fd_use_rs = 1'b1;
  endtask

  // Output vector order: {stall_front, bubble_dx, bubble_xm, md_start, md_done, md_error}
  task automatic run_md(input string tag, input int n_busy, input logic rdy_last,
                        input logic exc_last, input logic err_exp);
    dx_is_multdiv = 1'b1;
    md_ready = 1'b1;
    #1 chk_out({tag, "_start"}, 6'b101100);
    tick();
    md_ready = 1'b0;
    for (int i = 1; i <= n_busy; i++) begin
      if (i == n_busy) begin
        md_ready = rdy_last;
        md_exception = exc_last;
        #1 chk_out({tag, "_busy_last"}, 6'b101000);
      end
      tick();
    end
    md_ready = 1'b0;
    md_exception = 1'b0;
    #1 chk_out({tag, "_done"}, {4'b0000, 1'b1, err_exp});
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    dx_is_multdiv = 1'b1;
    #3;
    chk_out("reset_outputs", 6'b000000);
    chk("reset_count", stall_count, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    tick();

    set_load_use();
    #1 chk_out("lu_rs", 6'b110000);
    tick();
    clear_inputs();
    #1 chk("lu_count", stall_count, 16'd1);
    chk_out("lu_after", 6'b000000);

    dx_is_load = 1'b1; dx_rwe = 1'b1; fd_use_rs = 1'b1;
    #1 chk_out("lu_r0", 6'b000000);
    dx_rd = 5'd5; fd_rs = 5'd0; fd_use_rs = 1'b0; fd_rt = 5'd5; fd_use_rt = 1'b0;
    #1 chk_out("lu_rt_unused", 6'b000000);
    fd_use_rt = 1'b1;
    #1 chk_out("lu_rt", 6'b110000);
    fd_use_rt = 1'b0;
    tick();
    clear_inputs();
    #1 chk("no_stall_count", stall_count, 16'd1);

    run_md("mul", 4, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    #1 chk_out("mul_idle", 6'b000000);
    chk("mul_count", stall_count, 16'd6);

    run_md("div_exc", 1, 1'b1, 1'b1, 1'b1);
    tick();
    run_md("timeout", 40, 1'b0, 1'b0, 1'b1);
    tick();
    run_md("ready_last", 40, 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    #1 chk("md_count", stall_count, 16'd90);

    dx_is_multdiv = 1'b1;
    tick();
    dx_is_multdiv = 1'b0;
    tick();
    #1 chk_out("rst_busy2_pre", 6'b101000);
    reset = 1'b0;
    #1 chk_out("rst_busy2_out", 6'b000000);
    chk("rst_busy2_count", stall_count, 16'd0);
    chk("rst_busy2_sat_count", {28'd0, s_stall_count}, 32'd0);
    #1 reset = 1'b1;
    dx_is_multdiv = 1'b1;
    #1 chk_out("rst_release_idle", 6'b101100);
    dx_is_multdiv = 1'b0;
    tick();
    #1 chk_out("rst_release_next", 6'b000000);

    set_load_use();
    for (int i = 0; i < 15; i++) tick();
    #1 chk("sat_at_15", {28'd0, s_stall_count}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    #1 chk("sat_hold", {28'd0, s_stall_count}, 32'd15);
    chk("wide_count_20", stall_count, 16'd20);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
